// File: rtl/gpio_port_controller.sv
// Memory-mapped bidirectional GPIO: direction/output regs, 2-flop input sync, edge-capture level IRQ.
// Reads are combinational and writes take effect on the cpu_clk edge; the bus is never stalled.
module gpio_port_controller #(
  parameter int          GPIO_PINS = 13,
  parameter logic [31:0] ADDRESS   = 32'h6000_0000
) (
  input  logic                 cpu_clk,
  input  logic                 rst,
  input  logic                 data_rw,
  input  logic                 data_cs,
  input  logic [29:0]          data_address,
  inout  wire  [31:0]          data_bus,
  inout  wire  [GPIO_PINS-1:0] gpio,
  output logic                 irq
);

  localparam logic [29:0] BASE_WORD    = ADDRESS[31:2];
  localparam logic [29:0] OFF_DATA_IN  = 30'd0;
  localparam logic [29:0] OFF_DATA_OUT = 30'd1;
  localparam logic [29:0] OFF_DIR      = 30'd2;
  localparam logic [29:0] OFF_IRQ_EN   = 30'd3;
  localparam logic [29:0] OFF_IRQ_EDGE = 30'd4;
  localparam logic [29:0] OFF_IRQ_STAT = 30'd5;

  logic [29:0]          off;
  logic                 sel;
  logic                 rd_en;
  logic                 wr_en;
  logic [31:0]          rd_dat;
  logic [GPIO_PINS-1:0] wr_dat;

  logic [GPIO_PINS-1:0] out_reg;
  logic [GPIO_PINS-1:0] dir_reg;
  logic [GPIO_PINS-1:0] irq_en;
  logic [GPIO_PINS-1:0] edge_sel;
  logic [GPIO_PINS-1:0] irq_status;
  logic [GPIO_PINS-1:0] sync1;
  logic [GPIO_PINS-1:0] sync2;
  logic [GPIO_PINS-1:0] prev;

  logic [GPIO_PINS-1:0] rise;
  logic [GPIO_PINS-1:0] fall;
  logic [GPIO_PINS-1:0] hit;
  logic [GPIO_PINS-1:0] w1c_mask;

  // Addresses below the base wrap to a huge offset, so one compare covers both ends of the window.
  assign off    = data_address - BASE_WORD;
  assign sel    = data_cs && (off < 30'd6);
  assign rd_en  = sel && !data_rw;
  assign wr_en  = sel && data_rw;
  assign wr_dat = data_bus[GPIO_PINS-1:0];

  always_comb begin
    rd_dat = '0;
    case (off)
      OFF_DATA_IN:  rd_dat = 32'(sync2);
      OFF_DATA_OUT: rd_dat = 32'(out_reg);
      OFF_DIR:      rd_dat = 32'(dir_reg);
      OFF_IRQ_EN:   rd_dat = 32'(irq_en);
      OFF_IRQ_EDGE: rd_dat = 32'(edge_sel);
      OFF_IRQ_STAT: rd_dat = 32'(irq_status);
      default:      rd_dat = '0;
    endcase
  end

  assign data_bus = rd_en ? rd_dat : 32'bz;

  for (genvar i = 0; i < GPIO_PINS; i++) begin : g_pad
    assign gpio[i] = dir_reg[i] ? out_reg[i] : 1'bz;
  end

  assign rise     = sync2 & ~prev;
  assign fall     = ~sync2 & prev;
  assign hit      = irq_en & ((edge_sel & fall) | (~edge_sel & rise));
  assign w1c_mask = (wr_en && (off == OFF_IRQ_STAT)) ? wr_dat : '0;

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      out_reg    <= '0;
      dir_reg    <= '0;
      irq_en     <= '0;
      edge_sel   <= '0;
      irq_status <= '0;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      irq        <= 1'b0;
    end else begin
      sync1      <= gpio;
      sync2      <= sync1;
      prev       <= sync2;
      irq        <= |(irq_status & irq_en);
      // A fresh edge on the same cycle as its W1C keeps the flag set.
      irq_status <= (irq_status & ~w1c_mask) | hit;
      if (wr_en) begin
        case (off)
          OFF_DATA_OUT: out_reg  <= wr_dat;
          OFF_DIR:      dir_reg  <= wr_dat;
          OFF_IRQ_EN:   irq_en   <= wr_dat;
          OFF_IRQ_EDGE: edge_sel <= wr_dat;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_port_controller.sv
// Bench for gpio_port_controller: directed scenarios with literal expectations, then random bus/pin
// traffic, all compared every cycle against a sample-history reference model.
module tb_gpio_port_controller;
  localparam int          NP   = 13;
  localparam logic [31:0] ADDR = 32'h6000_0000;
  localparam logic [29:0] BW   = ADDR[31:2];

  logic        cpu_clk = 1'b0;
  logic        rst;
  logic        data_rw;
  logic        data_cs;
  logic [29:0] data_address;
  wire  [31:0] data_bus;
  wire  [NP-1:0] gpio;
  logic        irq;

  logic          bus_oe;
  logic [31:0]   bus_wdat;
  logic [NP-1:0] tb_oe;
  logic [NP-1:0] tb_val;

  // Reference model state
  logic [NP-1:0] m_out  = '0;
  logic [NP-1:0] m_dir  = '0;
  logic [NP-1:0] m_en   = '0;
  logic [NP-1:0] m_edge = '0;
  logic [NP-1:0] m_stat = '0;
  logic          m_irq  = 1'b0;
  logic [NP-1:0] pin_q[$];   // pin samples, newest first

  int   n_chk  = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;

  gpio_port_controller #(.GPIO_PINS(NP), .ADDRESS(ADDR)) dut (
    .cpu_clk      (cpu_clk),
    .rst          (rst),
    .data_rw      (data_rw),
    .data_cs      (data_cs),
    .data_address (data_address),
    .data_bus     (data_bus),
    .gpio         (gpio),
    .irq          (irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Pull-ups make an undriven (high-impedance) bit observable as 1.
  for (genvar i = 0; i < 32; i++) begin : g_bus_pu
    pullup (data_bus[i]);
  end
  for (genvar i = 0; i < NP; i++) begin : g_pin
    pullup (gpio[i]);
    assign gpio[i] = (tb_oe[i] && !m_dir[i]) ? tb_val[i] : 1'bz;
  end
  assign data_bus = bus_oe ? bus_wdat : 32'bz;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int offset_of(input logic [29:0] a);
    return int'(a) - int'(BW);
  endfunction

  function automatic logic [NP-1:0] exp_pins();
    logic [NP-1:0] p;
    for (int i = 0; i < NP; i++)
      p[i] = m_dir[i] ? m_out[i] : (tb_oe[i] ? tb_val[i] : 1'b1);
    return p;
  endfunction

  function automatic logic [31:0] m_reg(input int o);
    case (o)
      0: return 32'(pin_q[1]);
      1: return 32'(m_out);
      2: return 32'(m_dir);
      3: return 32'(m_en);
      4: return 32'(m_edge);
      5: return 32'(m_stat);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] exp_bus();
    int o;
    o = offset_of(data_address);
    if (data_cs && !data_rw && o >= 0 && o <= 5) return m_reg(o);
    if (bus_oe) return bus_wdat;
    return 32'hFFFF_FFFF;
  endfunction

  // Model advances on each clock edge from the inputs held stable since the previous edge.
  always @(posedge cpu_clk) begin
    logic [NP-1:0] smp, hit, cur, old, wd;
    logic [31:0]   eb;
    int            o;
    smp = exp_pins();
    if (rst) begin
      m_out = '0; m_dir = '0; m_en = '0; m_edge = '0; m_stat = '0; m_irq = 1'b0;
      pin_q = '{'0, '0, '0};
    end else begin
      cur = pin_q[1];
      old = pin_q[2];
      for (int i = 0; i < NP; i++)
        hit[i] = m_en[i] && (m_edge[i] ? (!cur[i] && old[i]) : (cur[i] && !old[i]));
      m_irq = |(m_stat & m_en);
      eb = exp_bus();
      wd = eb[NP-1:0];
      o  = offset_of(data_address);
      if (data_cs && data_rw && o >= 0 && o <= 5) begin
        case (o)
          1: m_out  = wd;
          2: m_dir  = wd;
          3: m_en   = wd;
          4: m_edge = wd;
          5: m_stat = m_stat & ~wd;
          default: ;
        endcase
      end
      m_stat = m_stat | hit;
      pin_q.push_front(smp);
      void'(pin_q.pop_back());
    end
  end

  always @(negedge cpu_clk) begin
    if (chk_en) begin
      check("bus", data_bus, exp_bus());
      check("gpio", 32'(gpio), 32'(exp_pins()));
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic cyc();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle();
    data_cs = 1'b0;
    data_rw = 1'b0;
    bus_oe  = 1'b0;
  endtask

  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    data_cs = 1'b1; data_rw = 1'b1; data_address = a; bus_oe = 1'b1; bus_wdat = d;
    cyc();
    idle();
  endtask

  task automatic bus_read(input logic [29:0] a, input logic [31:0] exp, input string nm);
    data_cs = 1'b1; data_rw = 1'b0; data_address = a; bus_oe = 1'b0;
    @(negedge cpu_clk);
    #1;
    check(nm, data_bus, exp);
    cyc();
    idle();
  endtask

  initial begin
    rst = 1'b1; data_cs = 1'b0; data_rw = 1'b0; data_address = BW;
    bus_oe = 1'b0; bus_wdat = '0; tb_oe = '0; tb_val = '0;
    pin_q = '{'0, '0, '0};

    // T1: reset with pins pulled high
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    check("t1_irq", 32'(irq), 32'h0);
    check("t1_gpio_z", 32'(gpio), 32'h1FFF);
    bus_read(BW + 30'd5, 32'h0, "t1_status");
    bus_read(BW, 32'h0, "t1_din_early");
    bus_read(BW, 32'h1FFF, "t1_din");

    // T2: outputs on pins 7:4, others driven low by the bench
    tb_oe = '1; tb_val = '0;
    bus_write(BW + 30'd2, 32'h0000_00F0);
    bus_write(BW + 30'd1, 32'h0000_1FFF);
    check("t2_gpio", 32'(gpio), 32'h00F0);
    bus_read(BW + 30'd1, 32'h1FFF, "t2_data_out");
    bus_read(BW + 30'd2, 32'h00F0, "t2_dir");

    // T3: rising edge on pin 0
    bus_write(BW + 30'd4, 32'h0);
    bus_write(BW + 30'd3, 32'h1);
    tb_val[0] = 1'b1;
    cyc();
    cyc();
    bus_read(BW + 30'd5, 32'h0, "t3_status_pre");
    check("t3_irq_pre", 32'(irq), 32'h0);
    bus_read(BW + 30'd5, 32'h1, "t3_status");
    check("t3_irq", 32'(irq), 32'h1);
    bus_write(BW + 30'd5, 32'h1);
    cyc();
    check("t3_irq_clr", 32'(irq), 32'h0);

    // T4: falling edge on pin 3, pin 2 rises but is masked
    tb_val[3] = 1'b1;
    repeat (4) cyc();
    bus_write(BW + 30'd4, 32'h8);
    bus_write(BW + 30'd3, 32'h8);
    tb_val[3] = 1'b0;
    tb_val[2] = 1'b1;
    repeat (4) cyc();
    bus_read(BW + 30'd5, 32'h8, "t4_status");
    bus_write(BW + 30'd5, 32'h8);
    tb_val[3] = 1'b1;
    repeat (5) cyc();
    bus_read(BW + 30'd5, 32'h0, "t4_rise_ignored");
    check("t4_irq", 32'(irq), 32'h0);

    // T5: W1C coincides with a new rising edge on pin 0
    bus_write(BW + 30'd4, 32'h0);
    bus_write(BW + 30'd3, 32'h1);
    tb_val[0] = 1'b0;
    repeat (4) cyc();
    tb_val[0] = 1'b1;
    repeat (4) cyc();
    bus_read(BW + 30'd5, 32'h1, "t5_status_set");
    tb_val[0] = 1'b0;
    repeat (3) cyc();
    tb_val[0] = 1'b1;
    cyc();
    cyc();
    bus_write(BW + 30'd5, 32'h1);
    bus_read(BW + 30'd5, 32'h1, "t5_status_kept");
    check("t5_irq", 32'(irq), 32'h1);

    // T6: decode boundaries and reset during a write
    bus_read(BW + 30'd6, 32'hFFFF_FFFF, "t6_off6_z");
    bus_read(BW - 30'd1, 32'hFFFF_FFFF, "t6_below_z");
    bus_write(BW + 30'd6, 32'h0);
    bus_write(BW - 30'd1, 32'h0);
    bus_read(BW + 30'd1, 32'h1FFF, "t6_out_kept");
    bus_read(BW + 30'd2, 32'h00F0, "t6_dir_kept");
    bus_read(BW + 30'd3, 32'h1, "t6_en_kept");
    rst = 1'b1;
    bus_write(BW + 30'd1, 32'h1555);
    rst = 1'b0;
    bus_read(BW + 30'd1, 32'h0, "t6_rst_write");
    bus_read(BW + 30'd2, 32'h0, "t6_rst_dir");

    // Random traffic against the model
    repeat (3000) begin
      data_cs      = ($urandom_range(0, 3) != 0);
      data_rw      = 1'($urandom_range(0, 1));
      data_address = BW + 30'($urandom_range(0, 7)) - 30'd1;
      bus_wdat     = $urandom;
      bus_oe       = data_cs && data_rw;
      rst          = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) tb_val = tb_val ^ (NP'($urandom) & NP'($urandom));
      if ($urandom_range(0, 31) == 0) tb_oe = NP'($urandom);
      cyc();
    end
    idle();
    rst = 1'b0;
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
